// File: rtl/sdwr_pkg.sv
// sdwr_pkg: shared states, protocol constants and CRC16 helper for the SD block writer
package sdwr_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_DRESP, S_BUSYW, S_END, S_ERR
  } state_t;
  localparam logic [7:0] CMD24 = 8'h58;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [4:0] DATA_ACCEPTED = 5'h05;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_R1 = 2'd1;
  localparam logic [1:0] ERR_DRESP = 2'd2;
  localparam logic [1:0] ERR_BUSY = 2'd3;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/sdwr_spi_byte.sv
// sdwr_spi_byte: mode-0 SPI byte shifter; last flags the cycle before the final falling edge
module sdwr_spi_byte #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       DO,
  output logic       sclk,
  output logic       di,
  output logic [7:0] rx,
  output logic       last
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic [2:0] bitc;
  logic [7:0] sh;
  logic busy, tick;
  assign tick = busy && div == DW'(CLK_DIV - 1);
  assign last = tick && sclk && bitc == 3'd7;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      sclk <= 1'b0;
      di <= 1'b1;
      div <= '0;
      bitc <= '0;
      sh <= '1;
      rx <= '1;
    end else if (start) begin
      busy <= 1'b1;
      sclk <= 1'b0;
      di <= tx[7];
      sh <= {tx[6:0], 1'b1};
      div <= '0;
      bitc <= '0;
    end else if (busy) begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        sclk <= !sclk;
        if (!sclk) rx <= {rx[6:0], DO};
        else begin
          bitc <= bitc + 3'd1;
          di <= sh[7];
          sh <= {sh[6:0], 1'b1};
          if (bitc == 3'd7) busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/sdwr_block_writer.sv
// sdwr_block_writer: SPI-mode CMD24 single-block writer; define SDWR_CRC16_EN to send a real CRC16
module sdwr_block_writer import sdwr_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int R1_POLL = 8,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] ADDR,
  output logic        DATA_RD,
  input  logic        DATA_VALID,
  input  logic [7:0]  DATA_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  input  logic        DO,
  output logic        CS,
  output logic        DI,
  output logic        SCLK
);
  localparam logic [9:0] R1P = 10'(R1_POLL - 1);
  localparam logic [16:0] BT = 17'(BUSY_TIMEOUT);
  state_t state, state_nx;
  logic [9:0] cnt, cnt_nx;
  logic [16:0] bcnt, bcnt_nx;
  logic [47:0] cmd_sr;
  logic [7:0] tx, rx, crc_hi, crc_lo;
  logic [1:0] code_nx;
  logic wait_d, wait_nx, cs_nx, busy_nx, rd_nx, done_nx, err_nx, go, shift, last, accept;
  assign accept = state == S_DATA && wait_d && DATA_VALID;
  sdwr_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk(CLK), .rst(RST), .start(go), .tx(tx), .DO(DO),
    .sclk(SCLK), .di(DI), .rx(rx), .last(last)
  );
`ifdef SDWR_CRC16_EN
  logic [15:0] crc;
  always_ff @(posedge CLK)
    if (RST || state == S_TOKEN) crc <= '0;
    else if (accept) crc <= crc16_byte(crc, DATA_IN);
  assign crc_hi = crc[15:8];
  assign crc_lo = crc[7:0];
`else
  assign crc_hi = 8'hFF;
  assign crc_lo = 8'hFF;
`endif
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    bcnt_nx = bcnt;
    wait_nx = wait_d;
    cs_nx = CS;
    busy_nx = BUSY;
    code_nx = ERR_CODE;
    rd_nx = 1'b0;
    done_nx = 1'b0;
    err_nx = 1'b0;
    go = 1'b0;
    shift = 1'b0;
    tx = 8'hFF;
    case (state)
      S_IDLE: if (START) begin
        state_nx = S_CMD; cnt_nx = '0; cs_nx = 1'b0; busy_nx = 1'b1; code_nx = ERR_NONE; go = 1'b1;
      end
      S_CMD: if (last) begin
        go = 1'b1;
        if (cnt == 10'd6) begin state_nx = S_R1; cnt_nx = '0; end
        else begin tx = cmd_sr[47:40]; shift = 1'b1; cnt_nx = cnt + 10'd1; end
      end
      S_R1: if (last) begin
        go = 1'b1;
        cnt_nx = cnt + 10'd1;
        if (rx == 8'h00) begin state_nx = S_TOKEN; cnt_nx = '0; end
        else if (rx != 8'hFF || cnt == R1P) begin state_nx = S_ERR; cs_nx = 1'b1; code_nx = ERR_R1; end
      end
      S_TOKEN: if (last) begin
        if (cnt == 10'd0) begin go = 1'b1; tx = START_TOKEN; cnt_nx = 10'd1; end
        else begin state_nx = S_DATA; cnt_nx = '0; rd_nx = 1'b1; wait_nx = 1'b1; end
      end
      S_DATA: begin
        if (accept) begin go = 1'b1; tx = DATA_IN; wait_nx = 1'b0; end
        if (last) begin
          cnt_nx = cnt + 10'd1;
          if (cnt == 10'd511) begin state_nx = S_CRC; go = 1'b1; tx = crc_hi; end
          else begin rd_nx = 1'b1; wait_nx = 1'b1; end
        end
      end
      S_CRC: if (last) begin
        go = 1'b1;
        if (cnt == 10'd0) begin tx = crc_lo; cnt_nx = 10'd1; end
        else begin state_nx = S_DRESP; cnt_nx = '0; end
      end
      S_DRESP: if (last) begin
        go = 1'b1;
        cnt_nx = cnt + 10'd1;
        if (rx[4:0] == DATA_ACCEPTED) begin state_nx = S_BUSYW; bcnt_nx = '0; end
        else if (rx != 8'hFF || cnt == R1P) begin state_nx = S_ERR; cs_nx = 1'b1; code_nx = ERR_DRESP; end
      end
      S_BUSYW: if (last) begin
        go = 1'b1;
        if (rx == 8'hFF) begin state_nx = S_END; cs_nx = 1'b1; end
        else if (bcnt == BT) begin state_nx = S_ERR; cs_nx = 1'b1; code_nx = ERR_BUSY; end
        else bcnt_nx = bcnt + 17'd1;
      end
      S_END: if (last) begin state_nx = S_IDLE; done_nx = 1'b1; busy_nx = 1'b0; end
      S_ERR: if (last) begin state_nx = S_IDLE; err_nx = 1'b1; busy_nx = 1'b0; end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt <= '0;
      bcnt <= '0;
      wait_d <= 1'b0;
      cmd_sr <= '1;
      CS <= 1'b1;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      ERR_CODE <= ERR_NONE;
      DATA_RD <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bcnt <= bcnt_nx;
      wait_d <= wait_nx;
      cmd_sr <= (state == S_IDLE && START) ? {CMD24, ADDR, 8'hFF} : shift ? {cmd_sr[39:0], 8'hFF} : cmd_sr;
      CS <= cs_nx;
      BUSY <= busy_nx;
      DONE <= done_nx;
      ERR <= err_nx;
      ERR_CODE <= code_nx;
      DATA_RD <= rd_nx;
    end
  end
endmodule

// File: tb/tb_sdwr_block_writer.sv
// tb_sdwr_block_writer: directed checks of the CMD24 writer against a scripted SD card model
module tb_sdwr_block_writer;
  logic CLK = 0, RST = 1, START = 0, DATA_VALID = 0;
  logic [31:0] ADDR = 0;
  logic [7:0] DATA_IN = 0;
  logic DO, DATA_RD, BUSY, DONE, ERR, CS, DI, SCLK;
  logic [1:0] ERR_CODE;
  int checks = 0, failures = 0;
  logic [7:0] r1 = 8'h00, dresp = 8'hE5;
  int busyn = 3;
  logic [7:0] cap [0:1023];
  logic [7:0] sh = 0;
  int ncap = 0, bitn = 0;
  int rd_cnt = 0, stall_idx = -1, stall_bad = 0, wc = 0;
  bit pend = 0, ff_data = 0;
  bit got_done, got_err, cs_at_end, busy_at_end;
  logic [1:0] got_code;

  always #5 CLK = ~CLK;

  sdwr_block_writer #(.CLK_DIV(2), .R1_POLL(8), .BUSY_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ADDR(ADDR), .DATA_RD(DATA_RD),
    .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .DO(DO), .CS(CS), .DI(DI), .SCLK(SCLK)
  );

  // card reply for byte n since CS fell: R1 at 7, data response at 524, then busy bytes
  function automatic logic resp_bit(int n, int b, logic [7:0] r1v, logic [7:0] drv, int bn);
    logic [7:0] v;
    v = n == 7 ? r1v : n == 524 ? drv : (n >= 525 && n < 525 + bn) ? 8'h00 : 8'hFF;
    return v[3'(7 - b)];
  endfunction
  assign DO = resp_bit(ncap, bitn, r1, dresp, busyn);

  always @(posedge SCLK) if (!CS) begin
    sh = {sh[6:0], DI};
    bitn = bitn + 1;
    if (bitn == 8) begin
      if (ncap < 1024) cap[ncap] = sh;
      ncap = ncap + 1;
      bitn = 0;
    end
  end
  always @(posedge CS) bitn = 0;

  always @(negedge CLK) begin
    DATA_VALID = 0;
    if (DATA_RD) begin
      pend = 1;
      wc = (rd_cnt == stall_idx) ? 20 : 0;
      DATA_IN = ff_data ? 8'hFF : 8'(rd_cnt);
      rd_cnt = rd_cnt + 1;
    end
    if (pend) begin
      if (wc == 0) begin DATA_VALID = 1; pend = 0; end
      else begin wc = wc - 1; if (SCLK || CS) stall_bad = stall_bad + 1; end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_wr(input logic [31:0] a);
    ncap = 0; rd_cnt = 0; pend = 0; stall_bad = 0;
    @(negedge CLK); ADDR = a; START = 1;
    @(negedge CLK); START = 0;
  endtask

  task automatic run(input int max);
    got_done = 0; got_err = 0;
    for (int i = 0; i < max && !got_done && !got_err; i++) begin
      @(negedge CLK);
      got_done = DONE; got_err = ERR; got_code = ERR_CODE;
      cs_at_end = CS; busy_at_end = BUSY;
    end
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    check("reset_outs", {CS, DI, SCLK, BUSY, DONE, ERR, DATA_RD}, 7'b1100000);
    check("reset_code", ERR_CODE, 0);
    RST = 1; START = 1;
    @(negedge CLK); RST = 0; START = 0;
    @(negedge CLK);
    check("rst_wins_start", {CS, BUSY}, 2'b10);

    stall_idx = 100;
    start_wr(32'h0000_1234);
    check("start_cs_busy", {CS, BUSY}, 2'b01);
    run(30000);
    check("wr1_done_err", {got_done, got_err}, 2'b10);
    check("wr1_cs_busy_end", {cs_at_end, busy_at_end}, 2'b10);
    check("wr1_cmd", {cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6]}, 56'hFF_58_00_00_12_34_FF);
    check("wr1_token", {cap[8], cap[9]}, 16'hFFFE);
    bad = 0;
    for (int i = 0; i < 512; i++) if (cap[10 + i] !== 8'(i)) bad++;
    check("wr1_data_errs", bad, 0);
`ifndef SDWR_CRC16_EN
    check("wr1_crc", {cap[522], cap[523]}, 16'hFFFF);
`endif
    check("wr1_nbytes", ncap, 529);
    check("wr1_rd_count", rd_cnt, 512);
    check("wr1_stall_sclk", stall_bad, 0);
    check("wr1_code", got_code, 0);
    @(negedge CLK);
    check("wr1_done_pulse", {DONE, BUSY}, 2'b00);

    stall_idx = -1; r1 = 8'h04;
    start_wr(32'h0000_0001);
    run(2000);
    check("r1bad_done_err", {got_done, got_err}, 2'b01);
    check("r1bad_code", got_code, 1);
    check("r1bad_nbytes", ncap, 8);
    check("r1bad_cs_end", {cs_at_end, busy_at_end}, 2'b10);
    repeat (5) @(negedge CLK);
    check("r1bad_code_held", ERR_CODE, 1);

    r1 = 8'hFF;
    start_wr(32'h0000_0002);
    check("code_cleared", ERR_CODE, 0);
    run(2000);
    check("r1to_code", {got_err, got_code}, 3'b101);
    check("r1to_nbytes", ncap, 15);

    r1 = 8'h00; dresp = 8'h0B; ff_data = 1;
    start_wr(32'h0000_0003);
    run(30000);
    check("dresp_done_err", {got_done, got_err}, 2'b01);
    check("dresp_code", got_code, 2);
    check("dresp_nbytes", ncap, 525);
`ifdef SDWR_CRC16_EN
    check("crc_ff", {cap[522], cap[523]}, 16'h7FA1);
`else
    check("crc_ff", {cap[522], cap[523]}, 16'hFFFF);
`endif

    dresp = 8'hE5; busyn = 1000000;
    start_wr(32'h0000_0004);
    run(30000);
    check("busy_done_err", {got_done, got_err}, 2'b01);
    check("busy_code", got_code, 3);
    check("busy_nbytes", ncap, 542);

    busyn = 3;
    start_wr(32'h0000_0005);
    for (int i = 0; i < 20000 && rd_cnt < 50; i++) @(negedge CLK);
    check("rst_reach_data", rd_cnt >= 50, 1);
    RST = 1;
    @(negedge CLK);
    RST = 0; pend = 0;
    check("rst_mid_cs", {CS, BUSY, SCLK}, 3'b100);
    run(2000);
    check("rst_mid_no_pulse", {got_done, got_err}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
